// File: rtl/sync_pattern_transmitter.sv
// Serial framer: sync pattern 1011 followed by the payload MSB first.
// Optional even parity bit after the payload when SYNC_TX_PARITY_EN is defined.
module sync_pattern_transmitter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              dout,
    output logic              busy,
    output logic              done
);

`ifdef SYNC_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              dout_q, dout_d;
    logic              done_q, done_d;
`ifdef SYNC_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SYNC_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
`ifdef SYNC_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // dout_d is the bit that will be on the line during the next cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dout_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SYNC_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = SYNC;
                    cnt_d   = 4'd0;
                    shreg_d = tx_data;
                    dout_d  = 1'b1;
`ifdef SYNC_TX_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            SYNC: begin
                if (cnt_q == 4'd3) begin
                    state_d = DATA;
                    cnt_d   = 4'(DATA_W - 1);
                    dout_d  = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
`ifdef SYNC_TX_PARITY_EN
                    par_d   = par_q ^ shreg_q[DATA_W-1];
`endif
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    dout_d = (cnt_q != 4'd0);
                end
            end
            DATA: begin
                if (cnt_q == 4'd0) begin
`ifdef SYNC_TX_PARITY_EN
                    state_d = PAR;
                    dout_d  = par_q;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    dout_d  = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
`ifdef SYNC_TX_PARITY_EN
                    par_d   = par_q ^ shreg_q[DATA_W-1];
`endif
                end
            end
`ifdef SYNC_TX_PARITY_EN
            PAR: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = ~tx_ready;
    assign dout     = dout_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sync_pattern_transmitter.sv
// Directed bench for sync_pattern_transmitter (DATA_W=8).
// Frames are collected bit by bit and compared with hand-built words.
module tb_sync_pattern_transmitter;

    localparam int DW = 8;
`ifdef SYNC_TX_PARITY_EN
    localparam int F = 13;
`else
    localparam int F = 12;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready, dout, busy, done;

    int checks = 0;
    int errors = 0;

    sync_pattern_transmitter #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .dout(dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] frame_of(input logic [7:0] d);
`ifdef SYNC_TX_PARITY_EN
        return 32'({4'b1011, d, ^d});
`else
        return 32'({4'b1011, d});
`endif
    endfunction

    // Entered just after the accept edge; leaves just after edge e0+F.
    task automatic collect(output logic [31:0] bits, output int rlow,
                           output int dseen, input int chg_at);
        bits  = '0;
        rlow  = 0;
        dseen = 0;
        for (int i = 0; i < F; i++) begin
            bits = {bits[30:0], dout};
            if (!tx_ready) rlow++;
            if (done) dseen++;
            if (i == chg_at) begin
                tx_data  = 8'hF0;
                tx_valid = 1'b1;
            end
            tick();
        end
    endtask

    task automatic start(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    logic [31:0] b;
    int rl, ds, seen, ndet;
    int det[2];
    logic [3:0] hist;

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_dout", dout, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single frame 0xA5
        start(8'hA5);
        collect(b, rl, ds, -1);
        check("a5_frame", b, frame_of(8'hA5));
        check("a5_busy_cycles", rl, F);
        check("a5_no_early_done", ds, 0);
        check("a5_done", done, 1);
        check("a5_dout_end", dout, 0);
        check("a5_ready_end", tx_ready, 1);
        tick();
        check("a5_done_once", done, 0);

`ifdef SYNC_TX_PARITY_EN
        start(8'h01);
        collect(b, rl, ds, -1);
        check("p01_frame", b, 32'h0000_1603);
        check("p01_done", done, 1);
        tick();
`endif

        // back-to-back with tx_valid held high
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        collect(b, rl, ds, -1);
        check("b2b1_frame", b, frame_of(8'h3C));
        check("b2b1_busy", rl, F);
        check("b2b1_done", done, 1);
        check("b2b_guard", dout, 0);
        tx_data = 8'hFF;
        tick();
        check("b2b2_start", dout, 1);
        collect(b, rl, ds, -1);
        tx_valid = 1'b0;
        check("b2b2_frame", b, frame_of(8'hFF));
        check("b2b2_busy", rl, F);
        check("b2b2_done", done, 1);
        tick();

        // data/valid changes mid-frame must be ignored
        start(8'h0F);
        collect(b, rl, ds, 2);
        tx_valid = 1'b0;
        check("mid_frame", b, frame_of(8'h0F));
        check("mid_done", done, 1);
        check("mid_no_done_early", ds, 0);
        tick();
        check("mid_no_accept", busy, 0);

        // reset in the middle of a frame
        start(8'hFF);
        repeat (5) tick();
        check("rst_mid_bit6", dout, 1);
        rst      = 1'b1;
        tx_valid = 1'b1;
        #1;
        check("rstm_dout", dout, 0);
        check("rstm_ready", tx_ready, 1);
        check("rstm_busy", busy, 0);
        check("rstm_done", done, 0);
        tick();
        check("rst_wins", busy, 0);
        rst      = 1'b0;
        tx_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < F + 2; i++) begin
            if (done) seen++;
            tick();
        end
        check("rst_no_done", seen, 0);
        start(8'h81);
        collect(b, rl, ds, -1);
        check("post_rst_frame", b, frame_of(8'h81));
        check("post_rst_done", done, 1);
        tick();

        // loopback into a 1011 detector
        start(8'hB0);
        collect(b, rl, ds, -1);
        check("lb_frame", b, frame_of(8'hB0));
        hist = '0;
        ndet = 0;
        det[0] = -1;
        det[1] = -1;
        for (int i = 0; i < F; i++) begin
            hist = {hist[2:0], b[F-1-i]};
            if (hist == 4'b1011) begin
                if (ndet < 2) det[ndet] = i;
                ndet++;
            end
        end
        $display("loopback detections at bit %0d and bit %0d", det[0], det[1]);
        check("lb_det_count", ndet, 2);
        check("lb_det_sync", det[0], 3);
        check("lb_det_payload", det[1], 7);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_pattern_transmitter.md
SYNC_PATTERN_TRANSMITTER -- requirements
Module: sync_pattern_transmitter

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, legal range 1..16.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port tx_valid  input  1  request to send the word on tx_data.
REQ-005 Port tx_data  input  DATA_W  payload word, sampled only at accept.
REQ-006 Port tx_ready  output  1  high only in IDLE; an accept is tx_valid && tx_ready at a rising edge.
REQ-007 Port dout  output  1  registered serial bit stream, one bit per clock.
REQ-008 Port busy  output  1  equals !tx_ready.
REQ-009 Port done  output  1  one-cycle pulse after a frame's last bit completes.

Function
REQ-010 The frame SHALL be the sync pattern 1,0,1,1, then tx_data MSB first, then the parity bit when enabled (REQ-025).
- Frame length F = 4 + DATA_W (+1 with parity).
REQ-011 The FSM SHALL have exactly these states: IDLE, SYNC (2-bit index 0..3), DATA (index DATA_W-1 down to 0), PAR.
REQ-012 IDLE SHALL drive dout=0 and tx_ready=1.
REQ-013 The transmitter SHALL, on accept at edge e0, capture tx_data into an internal shift register, enter SYNC, and drive dout=1 from e0.
- Latency from accept to first sync bit on dout is 0 edges.
REQ-014 Each following edge SHALL advance one bit: SYNC index 3 -> DATA MSB; DATA index 0 -> PAR, or -> IDLE when parity is disabled; PAR -> IDLE.
REQ-015 At edge e0+F the transmitter SHALL return to IDLE with dout=0 and done=1 for exactly that one cycle.
REQ-016 tx_valid and tx_data SHALL be ignored while busy; changing tx_data mid-frame SHALL NOT alter the transmitted bits.
REQ-017 Back-to-back: an accept during the done cycle SHALL start the next frame at that edge.
- Consecutive frames are therefore separated by exactly one guard 0 bit.
REQ-018 tx_valid held continuously high SHALL produce frames with period F+1.
REQ-019 done SHALL never be asserted in the same cycle as busy.
REQ-020 No output SHALL change except on a rising clk edge or an assertion of rst.

Reset
REQ-021 Asserting rst SHALL immediately force state=IDLE, dout=0, done=0, tx_ready=1, busy=0, and shift register=0.
REQ-022 Reset mid-frame SHALL abort the frame with no done pulse; the first accept after release SHALL start a complete fresh frame.
REQ-023 With rst and tx_valid both high at an edge, reset SHALL win and no accept SHALL occur.

Configuration
REQ-024 Macro SYNC_TX_PARITY_EN SHALL select whether a parity bit is sent.
REQ-025 With SYNC_TX_PARITY_EN defined, the PAR state SHALL emit even parity (XOR of all DATA_W payload bits) after the payload LSB, and F = 5 + DATA_W.
REQ-026 Without SYNC_TX_PARITY_EN, the PAR state and parity logic SHALL be absent, and done SHALL follow the payload LSB directly (F = 4 + DATA_W).

Verification
REQ-027 Reset release, accept 0xA5 (DATA_W=8, no parity) -> dout over 12 cycles = 1011 1010 0101, then 0 with done=1 at edge e0+12.
REQ-028 With SYNC_TX_PARITY_EN: 0xA5 -> frame ends with parity bit 0; 0x01 -> parity bit 1; done at edge e0+13.
REQ-029 tx_valid held high with 0x3C then 0xFF -> two frames separated by exactly one 0 bit; tx_ready low for the 12 cycles of each frame.
REQ-030 Accept 0x0F, then drive tx_data=0xF0 with tx_valid=1 mid-frame -> transmitted payload is still 00001111 and no extra accept occurs.
REQ-031 Assert rst at the 6th bit of a frame -> dout=0 and tx_ready=1 immediately, no done pulse; next accept of 0x81 -> full frame 1011 1000 0001.
REQ-032 Loopback check: the stream for 0xB0 (payload contains 1011) feeds a 1011 sequence detector -> detections at the sync pattern and at the payload's embedded pattern.
- The bench SHALL report both detection times.
